// File: rtl/byte_enabled_clear_ram.sv
// Byte-enabled RAM with a narrower read port and a word-per-cycle fast clear.
// The write port stores IN_W-bit words with per-lane enables. The read port
// returns OUT_W-bit sub-words after a two-cycle pipeline. A clear engine
// overwrites every word with CLEAR_VALUE, one word per cycle, while holding
// off all user traffic.
module byte_enabled_clear_ram #(
  parameter int WADDR_WIDTH = 6,
  parameter int RADDR_WIDTH = 8,
  parameter int BYTE_WIDTH  = 16,
  parameter int BYTES       = 4,
  parameter logic [BYTE_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [WADDR_WIDTH-1:0]              waddr,
  input  logic [BYTES-1:0]                    be,
  input  logic [BYTES*BYTE_WIDTH-1:0]         wdata,
  input  logic                                re,
  input  logic [RADDR_WIDTH-1:0]              raddr,
  output logic [BYTES*BYTE_WIDTH/(2**(RADDR_WIDTH-WADDR_WIDTH))-1:0] q,
  output logic                                q_valid,
  input  logic                                clear_start,
  output logic                                busy,
  output logic                                clear_done
);

  localparam int WORDS = 2**WADDR_WIDTH;
  localparam int SUBW  = RADDR_WIDTH - WADDR_WIDTH;
  localparam int RATIO = 2**SUBW;
  localparam int IN_W  = BYTES * BYTE_WIDTH;
  localparam int OUT_W = IN_W / RATIO;
  localparam int SELW  = (SUBW > 0) ? SUBW : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [WADDR_WIDTH-1:0] counter;
  logic [WADDR_WIDTH-1:0] counter_nxt;

  logic                   wr_en;
  logic [WADDR_WIDTH-1:0] wr_addr;
  logic [BYTES-1:0]       wr_be;
  logic [IN_W-1:0]        wr_data;

  logic [IN_W-1:0]        mem [WORDS];

  logic                   rd_acc;
  logic [SELW-1:0]        sel_in;
  logic                   rd_v1;
  logic [WADDR_WIDTH-1:0] rd_word1;
  logic [SELW-1:0]        rd_sel1;
  logic                   rd_v2;
  logic [IN_W-1:0]        rd_data2;
  logic [SELW-1:0]        rd_sel2;

  // The low read-address bits pick the sub-word; with equal widths there is only one.
  generate
    if (SUBW > 0) begin : g_sel
      assign sel_in = raddr[SELW-1:0];
    end else begin : g_nosel
      assign sel_in = '0;
    end
  endgenerate

  // Clear state and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Clear sequencing: start from word 0, flag done while the last word is written.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    busy        = 1'b0;
    clear_done  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt   = CLEAR;
          counter_nxt = '0;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        counter_nxt = counter + 1'b1;
        if (counter == WADDR_WIDTH'(WORDS - 1)) begin
          clear_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-port source: the clear engine owns the port while busy, otherwise the user.
  always_comb begin
    wr_en   = we;
    wr_addr = waddr;
    wr_be   = be;
    wr_data = wdata;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = counter;
      wr_be   = '1;
      wr_data = {BYTES{CLEAR_VALUE}};
    end
  end

  // Storage array with per-lane write; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign rd_acc = re && (state == IDLE);

  // Read pipeline: register the address, then the word (after that edge's write), then the sub-word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1    <= 1'b0;
      rd_word1 <= '0;
      rd_sel1  <= '0;
      rd_v2    <= 1'b0;
      rd_data2 <= '0;
      rd_sel2  <= '0;
      q_valid  <= 1'b0;
      q        <= '0;
    end else begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        rd_word1 <= raddr[RADDR_WIDTH-1 -: WADDR_WIDTH];
        rd_sel1  <= sel_in;
      end
      rd_v2 <= rd_v1;
      if (rd_v1) begin
        rd_data2 <= mem[rd_word1];
        rd_sel2  <= rd_sel1;
      end
      q_valid <= rd_v2;
      if (rd_v2) begin
        q <= rd_data2[int'(rd_sel2)*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: doc/byte_enabled_clear_ram.md
BYTE_ENABLED_CLEAR_RAM -- requirements
Module: byte_enabled_clear_ram

Interface
REQ-001 The block SHALL have parameter WADDR_WIDTH, default 6, meaning write-port word address width; depth WORDS = 2**WADDR_WIDTH.
REQ-002 The block SHALL have parameter RADDR_WIDTH, default 8, meaning read-port address width; must be >= WADDR_WIDTH; RATIO = 2**(RADDR_WIDTH-WADDR_WIDTH).
REQ-003 The block SHALL have parameter BYTE_WIDTH, default 16, meaning lane width in bits (any value; not limited to 8/9).
REQ-004 The block SHALL have parameter BYTES, default 4, meaning lanes per write word; IN_W = BYTES*BYTE_WIDTH; OUT_W = IN_W/RATIO; BYTES must be divisible by RATIO.
REQ-005 The block SHALL have parameter CLEAR_VALUE, default 0, width BYTE_WIDTH, meaning the value written to every lane during a fast clear.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port we, input, 1, write request.
REQ-009 The block SHALL have port waddr, input, WADDR_WIDTH, write word address.
REQ-010 The block SHALL have port be, input, BYTES, per-lane write enable; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-011 The block SHALL have port wdata, input, IN_W, write data.
REQ-012 The block SHALL have port re, input, 1, read request.
REQ-013 The block SHALL have port raddr, input, RADDR_WIDTH, read address; the low RADDR_WIDTH-WADDR_WIDTH bits select the sub-word, and sub-word 0 is the least-significant OUT_W bits.
REQ-014 The block SHALL have port q, output, OUT_W, read data.
REQ-015 The block SHALL have port q_valid, output, 1, which qualifies q for exactly one cycle.
REQ-016 The block SHALL have port clear_start, input, 1, a single-cycle request to start a fast clear.
REQ-017 The block SHALL have port busy, output, 1, which is high while a clear is in progress.
REQ-018 The block SHALL have port clear_done, output, 1, a one-cycle pulse when a clear completes.

Function
REQ-019 The storage array SHALL be inferred as WORDS x IN_W with per-lane write; it SHALL NOT be reset.
REQ-020 A write with we=1 and busy=0 SHALL update only the lanes whose be bit is 1; the array is updated at that clock edge.
REQ-021 A read with re=1 and busy=0 at edge N SHALL drive q and q_valid=1 after edge N+2 (2-cycle latency: one registered address, one registered output); re is accepted back-to-back every cycle.
REQ-022 When re=0 or busy=1 at edge N, q_valid SHALL be 0 after edge N+2, and q SHALL hold its last value.
REQ-023 A same-cycle read and write to the same word (raddr upper WADDR_WIDTH bits == waddr) SHALL return the newly written lanes merged with the old unwritten lanes.
REQ-024 A write at edge N+1 to a word read at edge N SHALL NOT affect the data returned for that read.
REQ-025 The clear state machine SHALL have states IDLE and CLEAR; clear_start=1 in IDLE SHALL go to CLEAR with counter=0 and busy=1 from the next cycle.
REQ-026 In CLEAR, the block SHALL write CLEAR_VALUE to all lanes of word[counter] each cycle and increment the counter, so a clear takes exactly WORDS cycles.
REQ-027 When counter == WORDS-1 is written, the block SHALL return to IDLE, pulse clear_done for that cycle, and deassert busy on the next cycle.
REQ-028 While busy=1, we, re and clear_start SHALL be ignored: no write, no new read accepted, no restart.
REQ-029 Reads accepted before a clear started SHALL still complete with pre-clear data.
REQ-030 If clear_start is asserted in the same cycle as we or re, the write or read SHALL be performed and the clear SHALL begin on the next cycle.

Reset
REQ-031 While rst_n=0, the block SHALL force: state IDLE, counter 0, busy 0, clear_done 0, q_valid 0, q 0, and the read pipeline flushed.
REQ-032 Reset asserted mid-clear SHALL abort the clear immediately; memory contents are then undefined (partially cleared) and no clear_done is produced.
REQ-033 After rst_n deasserts, the first operation SHALL be accepted on the first rising edge.

Verification
REQ-034 Defaults: write waddr=5, be=4'b0101, wdata=64'hAAAA_BBBB_CCCC_DDDD over prior 0, then read raddr=20,21,22,23 -> q=16'hDDDD, 0, 16'hBBBB, 0, with q_valid on 4 consecutive cycles starting 2 cycles after the first re.
REQ-035 Same-cycle write waddr=3, be=4'b0010, wdata lane1=16'h1234 and read raddr=13 -> q=16'h1234 two cycles later; a write at the next edge does not alter it.
REQ-036 clear_start with CLEAR_VALUE=16'h7FFF -> busy high for exactly 64 cycles, clear_done is a single pulse, and every raddr then reads 16'h7FFF; we, re and clear_start during busy have no effect.
REQ-037 rst_n pulsed low at clear cycle 30 -> busy, q_valid, q and clear_done are 0 immediately; words 0..29 read CLEAR_VALUE, and a new clear completes normally.
REQ-038 Parameter sweep RADDR_WIDTH=WADDR_WIDTH=4, BYTE_WIDTH=9, BYTES=2: a random write/read scoreboard over 10k cycles shows zero mismatches.
